// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared constants for the UART block: data width, receive FIFO depth, the
// pointer/occupancy widths derived from the depth, and the bus register map
// offsets used by the register file.
// -----------------------------------------------------------------------------
package uart_pkg;

  // Byte width carried by the receiver and the FIFO.
  localparam int UART_DATA_W = 8;

  // Receive FIFO depth; must be a power of two so the pointers wrap for free.
  localparam int UART_RXFIFO_DEPTH = 16;

  // Pointer width indexes DEPTH entries; occupancy needs one more bit so that
  // "exactly DEPTH stored" is representable.
  localparam int UART_RXFIFO_PTR_W = $clog2(UART_RXFIFO_DEPTH);
  localparam int UART_RXFIFO_CNT_W = UART_RXFIFO_PTR_W + 1;

  // Bus register map offsets (byte addresses).
  typedef enum logic [7:0] {
    UART_REG_RXD = 8'h00,  // receive data: head of the RX FIFO
    UART_REG_CON = 8'h04   // control/status: irq enable, overrun, count
  } uart_reg_e;

  localparam logic [7:0] UART_RXD_OFFSET = 8'h00;
  localparam logic [7:0] UART_CON_OFFSET = 8'h04;

endpackage : uart_pkg

// File: rtl/uart_rx_fifo_sync.sv
// -----------------------------------------------------------------------------
// rx_status_sync
// Single-bit two-flop synchronizer followed by a rising-edge detector. The
// input is a level from a foreign clock domain; the output pulses for exactly
// one clk cycle per rising edge of that level. Also used on the TX status path.
//
// Ports
//   clk_i    in   destination-domain clock
//   reset_i  in   synchronous, active-high reset; clears all three flops
//   async_i  in   level from the other clock domain
//   rise_o   out  one-cycle pulse, high in the cycle after the second
//                 synchronizer stage first sees the new high level
// -----------------------------------------------------------------------------
module rx_status_sync (
  input  logic clk_i,
  input  logic reset_i,
  input  logic async_i,
  output logic rise_o
);

  // s1/s2 form the synchronizer; s3 remembers the previous synchronized
  // level so a rising edge can be detected without touching async_i again.
  logic s1_q;
  logic s2_q;
  logic s3_q;

  // Synchronizer chain and edge-history flop.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= async_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // Decoded from flops only, so downstream sees no path from async_i.
  assign rise_o = s2_q & ~s3_q;

endmodule : rx_status_sync

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// Receive buffer between the oversampled UART receiver and the bus register
// file. Each completed byte (signalled by a rising edge of rx_status_i, which
// lives in the clk16 domain) is captured into a DEPTH-entry FIFO. The oldest
// byte is shown on rd_data_o (show-ahead) and removed by a pop_i strobe.
// Occupancy, full/empty, a sticky overrun flag and a receive interrupt are
// reported; all of them are decoded from registered state only.
//
// Ports
//   clk_i          in   bus-side system clock, sole clock of the block
//   reset_i        in   synchronous, active-high reset
//   rx_data_i      in   received byte; stable while rx_status_i is high
//   rx_status_i    in   receiver "byte complete" level (asynchronous)
//   pop_i          in   CPU read strobe, removes the head entry
//   clr_overrun_i  in   clears the sticky overrun flag
//   irq_en_i       in   receive-interrupt enable
//   rd_data_o      out  head entry, 0 when empty
//   empty_o        out  no entries stored
//   full_o         out  count_o == DEPTH
//   count_o        out  current occupancy, 0..DEPTH
//   overrun_o      out  sticky: a byte was dropped because the FIFO was full
//   irq_o          out  irq_en_i & ~empty_o
// -----------------------------------------------------------------------------
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = UART_RXFIFO_DEPTH,
  parameter int DATA_W = UART_DATA_W
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [DATA_W-1:0]        rx_data_i,
  input  logic                     rx_status_i,
  input  logic                     pop_i,
  input  logic                     clr_overrun_i,
  input  logic                     irq_en_i,
  output logic [DATA_W-1:0]        rd_data_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overrun_o,
  output logic                     irq_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [DATA_W-1:0] DATA_ZERO = DATA_W'(0);

  // Storage: not reset, only the pointers and count define what is valid.
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] wp_q;
  logic [PTR_W-1:0] wp_d;
  logic [PTR_W-1:0] rp_q;
  logic [PTR_W-1:0] rp_d;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             overrun_q;
  logic             overrun_d;

  logic push_s;
  logic empty_s;
  logic full_s;
  logic do_pop_s;
  logic do_push_s;
  logic drop_s;

  // One push pulse per rx_status rising edge, after crossing into clk.
  rx_status_sync u_rx_status_sync (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .async_i (rx_status_i),
    .rise_o  (push_s)
  );

  assign empty_s = (count_q == CNT_ZERO);
  assign full_s  = (count_q == CNT_FULL);

  // A pop on an empty FIFO does nothing. A push is taken whenever there is
  // room, or when a simultaneous pop frees the slot it needs. Only when full
  // without a pop is the byte discarded; that is what sets overrun.
  assign do_pop_s  = pop_i & ~empty_s;
  assign do_push_s = push_s & (~full_s | do_pop_s);
  assign drop_s    = push_s & full_s & ~pop_i;

  // Next-state for pointers, occupancy and the sticky overrun flag.
  always_comb begin
    wp_d      = wp_q;
    rp_d      = rp_q;
    count_d   = count_q;
    overrun_d = overrun_q;

    // Pointers wrap modulo DEPTH through natural overflow (DEPTH is 2^n).
    if (do_push_s) begin
      wp_d = wp_q + PTR_ONE;
    end else begin
      wp_d = wp_q;
    end

    if (do_pop_s) begin
      rp_d = rp_q + PTR_ONE;
    end else begin
      rp_d = rp_q;
    end

    // Push and pop together leave the occupancy unchanged.
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // A new drop outranks a clear arriving in the same cycle, so the CPU
    // never clears an overrun it has not yet had a chance to observe.
    if (drop_s) begin
      overrun_d = 1'b1;
    end else if (clr_overrun_i) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wp_q      <= {PTR_W{1'b0}};
      rp_q      <= {PTR_W{1'b0}};
      count_q   <= CNT_ZERO;
      overrun_q <= 1'b0;
    end else begin
      wp_q      <= wp_d;
      rp_q      <= rp_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  // Storage write port; rx_data_i is already stable when the push arrives,
  // so it is written directly without its own synchronizer.
  always_ff @(posedge clk_i) begin
    if (do_push_s && !reset_i) begin
      mem_q[wp_q] <= rx_data_i;
    end
  end

  // Show-ahead read: the head entry, forced to zero when nothing is stored so
  // stale array contents never leak onto the bus.
  always_comb begin
    if (empty_s) begin
      rd_data_o = DATA_ZERO;
    end else begin
      rd_data_o = mem_q[rp_q];
    end
  end

  assign empty_o   = empty_s;
  assign full_o    = full_s;
  assign count_o   = count_q;
  assign overrun_o = overrun_q;
  assign irq_o     = irq_en_i & ~empty_s;

endmodule : uart_rx_fifo
